led_matrix_scan: RTL and testbench

- Time-multiplexed driver for the 7x5 LED matrix of the game board.
- Consumes the one-hot row selection from the row decoder (L0..L6) and a one-hot column selection.
- Scans one matrix row per scan period, showing either the ship map (positioning mode) or the hit map (attack mode).
- The selected cursor cell blinks on top of the displayed map.

---
 rtl/board_pkg.sv | 13 +
 rtl/pulse_div.sv | 24 ++
 rtl/led_matrix_scan.sv | 83 ++++++++
 tb/tb_led_matrix_scan.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// board_pkg: shared game-board geometry and map/row types.
package board_pkg;
    localparam int BOARD_ROWS = 7;
    localparam int BOARD_COLS = 5;
    localparam int MAP_W      = BOARD_ROWS * BOARD_COLS;

    typedef logic [MAP_W-1:0] board_map_t;
    typedef logic [2:0]       row_idx_t;

    function automatic logic is_onehot(input logic [31:0] x);
        return (x != '0) && ((x & (x - 32'd1)) == '0);
    endfunction
endpackage

// File: rtl/pulse_div.sv
// pulse_div: free-running divider with sync clear; tick is high on the last count of each period.
module pulse_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign tick = !clr && (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: row-multiplexed driver for the board LED matrix with a blinking cursor cell.
// Define LED_MATRIX_BLANK_EN to insert one dead cycle at the end of every row slot.
module led_matrix_scan
    import board_pkg::*;
#(
    parameter int ROWS        = BOARD_ROWS,
    parameter int COLS        = BOARD_COLS,
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_TICKS = 7000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 attack,
    input  logic [ROWS-1:0]      row_sel,
    input  logic [COLS-1:0]      col_sel,
    input  logic [ROWS*COLS-1:0] ship_map,
    input  logic [ROWS*COLS-1:0] hit_map,
    output logic [ROWS-1:0]      row_drv,
    output logic [COLS-1:0]      col_drv,
    output row_idx_t             scan_row
);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    logic            tick, blank, last_blink, cur_valid;
    row_idx_t        row_idx;
    logic [BW-1:0]   blink_cnt;
    logic            blink_ph;
    logic [COLS-1:0] map_row, cur_mask, col_nxt;

    pulse_div #(.DIV(SCAN_DIV)) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!en),
        .tick  (tick)
    );

`ifdef LED_MATRIX_BLANK_EN
    assign blank = tick;
`else
    assign blank = 1'b0;
`endif

    assign last_blink = blink_cnt == BW'(BLINK_TICKS - 1);
    assign cur_valid  = is_onehot(32'(row_sel)) && is_onehot(32'(col_sel));

    // Cursor cell shows the blink phase in place of the map bit.
    always_comb begin
        map_row = '0;
        for (int r = 0; r < ROWS; r++)
            if (row_idx == row_idx_t'(r))
                map_row = attack ? hit_map[r*COLS +: COLS] : ship_map[r*COLS +: COLS];
        cur_mask = (cur_valid && row_sel[row_idx]) ? col_sel : '0;
        col_nxt  = (map_row & ~cur_mask) | (cur_mask & {COLS{blink_ph}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx   <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            row_drv   <= '0;
            col_drv   <= '0;
            scan_row  <= '0;
        end else if (!en) begin
            row_idx   <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            row_drv   <= '0;
            col_drv   <= '0;
            scan_row  <= '0;
        end else begin
            if (tick) begin
                row_idx   <= (row_idx == row_idx_t'(ROWS - 1)) ? '0 : row_idx + 1'b1;
                blink_cnt <= last_blink ? '0 : blink_cnt + 1'b1;
                blink_ph  <= last_blink ? ~blink_ph : blink_ph;
            end
            row_drv  <= blank ? '0 : ROWS'(1) << row_idx;
            col_drv  <= blank ? '0 : col_nxt;
            scan_row <= row_idx;
        end
    end
endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: vector table plus per-cycle scoreboard against a behavioural matrix model.
`timescale 1ns/100ps
module tb_led_matrix_scan;
    import board_pkg::*;

    localparam int SD = 4;
    localparam int BT = 14;
    localparam int R  = BOARD_ROWS;
    localparam int C  = BOARD_COLS;

    logic         clk = 0, rst_n = 0, en = 0, attack = 0;
    logic [R-1:0] row_sel = '0;
    logic [C-1:0] col_sel = '0;
    board_map_t   ship_map = '0, hit_map = '0;
    logic [R-1:0] row_drv;
    logic [C-1:0] col_drv;
    row_idx_t     scan_row;

    always #5 clk = ~clk;

    led_matrix_scan #(.ROWS(R), .COLS(C), .SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .attack   (attack),
        .row_sel  (row_sel),
        .col_sel  (col_sel),
        .ship_map (ship_map),
        .hit_map  (hit_map),
        .row_drv  (row_drv),
        .col_drv  (col_drv),
        .scan_row (scan_row)
    );

    typedef struct packed {
        logic [R-1:0] rd;
        logic [C-1:0] cd;
        logic [2:0]   sr;
    } out_t;

    typedef struct {
        logic         att;
        logic [R-1:0] rs;
        logic [C-1:0] cs;
        board_map_t   sm;
        board_map_t   hm;
        int           frames;
        int           crow;
        logic [C-1:0] ca;
        logic [C-1:0] cb;
    } vec_t;

    out_t sb[$];
    int   m_cnt = 0, m_row = 0, m_bcnt = 0;
    logic m_ph = 0;
    int   passed = 0, total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_row = 0; m_bcnt = 0; m_ph = 0;
        sb.delete();
    endtask

    // Predict the next registered output from the inputs seen at the coming edge.
    task automatic step();
        out_t e, g;
        logic bv;
        @(negedge clk);
        e = '0;
        if (!en) begin
            m_cnt = 0; m_row = 0; m_bcnt = 0; m_ph = 0;
        end else begin
            e.rd = R'(1) << m_row;
            e.sr = 3'(m_row);
            for (int c = 0; c < C; c++) begin
                bv = attack ? hit_map[m_row*C + c] : ship_map[m_row*C + c];
                if ($countones(row_sel) == 1 && $countones(col_sel) == 1 && row_sel[m_row] && col_sel[c])
                    bv = m_ph;
                e.cd[c] = bv;
            end
`ifdef LED_MATRIX_BLANK_EN
            if (m_cnt == SD - 1) begin e.rd = '0; e.cd = '0; end
`endif
            if (m_cnt == SD - 1) begin
                m_cnt = 0;
                m_row = (m_row + 1) % R;
                if (m_bcnt == BT - 1) begin m_bcnt = 0; m_ph = ~m_ph; end
                else m_bcnt++;
            end else m_cnt++;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        g = sb.pop_front();
        chk("sb_row_drv",  32'(row_drv),  32'(g.rd));
        chk("sb_col_drv",  32'(col_drv),  32'(g.cd));
        chk("sb_scan_row", 32'(scan_row), 32'(g.sr));
    endtask

    function automatic logic blank_slot(input int k);
`ifdef LED_MATRIX_BLANK_EN
        return (k % SD) == SD - 1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [R-1:0] exp_row(input int k);
        return blank_slot(k) ? '0 : R'(1) << ((k / SD) % R);
    endfunction

    vec_t v[6];

    initial begin
        v[0] = '{1'b0, 7'b0000000, 5'b00000, 35'd1 << 7,      35'd1 << 33, 1, 1, 5'b00100, 5'b00100};
        v[1] = '{1'b1, 7'b0000000, 5'b00000, 35'd1 << 7,      35'd1 << 33, 1, 6, 5'b01000, 5'b01000};
        v[2] = '{1'b0, 7'b0001000, 5'b00001, 35'd0,           35'd0,       4, 3, 5'b00000, 5'b00001};
        v[3] = '{1'b0, 7'b0011000, 5'b00001, 35'b10101 << 15, 35'd0,       4, 3, 5'b10101, 5'b10101};
        v[4] = '{1'b0, 7'b0000100, 5'b00100, 35'b11111 << 10, 35'd0,       4, 2, 5'b11011, 5'b11111};
        v[5] = '{1'b1, 7'b0000001, 5'b00011, 35'd0,           35'b00110,   2, 0, 5'b00110, 5'b00110};

        #12;
        chk("rst_row_drv",  32'(row_drv),  32'd0);
        chk("rst_col_drv",  32'(col_drv),  32'd0);
        chk("rst_scan_row", 32'(scan_row), 32'd0);
        rst_n = 1;
        model_reset();
        for (int k = 0; k < 10; k++) begin
            step();
            chk("idle_row_drv", 32'(row_drv), 32'd0);
        end

        foreach (v[i]) begin
            attack = v[i].att; row_sel = v[i].rs; col_sel = v[i].cs;
            ship_map = v[i].sm; hit_map = v[i].hm;
            en = 0; step(); en = 1;
            for (int k = 0; k < v[i].frames * R * SD; k++) begin
                int r;
                logic [C-1:0] ec;
                step();
                r  = (k / SD) % R;
                ec = (r == v[i].crow) ? (((k / (2 * R * SD)) % 2 == 1) ? v[i].cb : v[i].ca) : '0;
                if (blank_slot(k)) ec = '0;
                chk($sformatf("vec%0d_row_drv", i), 32'(row_drv), 32'(exp_row(k)));
                chk($sformatf("vec%0d_col_drv", i), 32'(col_drv), 32'(ec));
            end
        end

        attack = 0; row_sel = '0; col_sel = '0; ship_map = '1; hit_map = '0;
        en = 0; step(); en = 1;
        for (int k = 0; k < 17; k++) step();
        chk("row4_reached", 32'(scan_row), 32'd4);
        en = 0; step();
        chk("dis_row_drv",  32'(row_drv),  32'd0);
        chk("dis_col_drv",  32'(col_drv),  32'd0);
        chk("dis_scan_row", 32'(scan_row), 32'd0);
        en = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("reen_row_drv", 32'(row_drv), 32'(exp_row(k)));
        end

        #1 rst_n = 0;
        #1;
        chk("arst_row_drv",  32'(row_drv),  32'd0);
        chk("arst_col_drv",  32'(col_drv),  32'd0);
        chk("arst_scan_row", 32'(scan_row), 32'd0);
        #1 rst_n = 1;
        model_reset();
        for (int k = 0; k < 10; k++) begin
            step();
            chk("post_rst_row_drv", 32'(row_drv), 32'(exp_row(k)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
